// File: rtl/cadder_seq.sv
// cadder_seq: sequences the registered 26-bit accumulate adder and saturates its sum to OUT_W bits.
// Latency: start to res_valid is len+2 cycles (len+3 with bias) plus one cycle per mul_valid-low stall.
// Backpressure: mul_valid low stalls SEED/ACC; res_ready low holds the result in OUT and blocks new jobs.
// Build option: define CADDER_SEQ_BIAS_EN to add one BIAS cycle per job (rega added once).
module cadder_seq #(
  parameter int LEN_W = 8,
  parameter int OUT_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             mul_valid,
  output logic             mul_ready,
  output logic             add_en,
  output logic [1:0]       add_sel,
  input  logic [25:0]      add_sum,
  input  logic             add_ovf,
  output logic [OUT_W-1:0] res_data,
  output logic             res_sat,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready
);

  // Adder input-select encodings.
  localparam logic [1:0] SEL_MUL_REGS = 2'b00;
  localparam logic [1:0] SEL_MUL_SUM  = 2'b01;
`ifdef CADDER_SEQ_BIAS_EN
  localparam logic [1:0] SEL_REGA_SUM = 2'b10;
`endif

  // Saturation bounds, both as 26-bit signed compare limits and as OUT_W-bit result words.
  localparam int                MAX_I   = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [25:0] SAT_MAX = 26'(MAX_I);
  localparam logic signed [25:0] SAT_MIN = 26'(-MAX_I - 1);
  localparam logic [OUT_W-1:0]   RES_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]   RES_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    ACC    = 3'd2,
`ifdef CADDER_SEQ_BIAS_EN
    BIAS   = 3'd3,
`endif
    SETTLE = 3'd4,
    OUT    = 3'd5
  } state_t;

  // State following the last multiplier term.
`ifdef CADDER_SEQ_BIAS_EN
  localparam state_t POST = BIAS;
`else
  localparam state_t POST = SETTLE;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic             ovf_sticky;
  logic             en_d;
  logic             accept;
  logic             fire;
  logic             ovf_final;
  logic [OUT_W-1:0] res_data_nxt;
  logic             res_sat_nxt;

  // Next-state and adder/handshake decode; all outputs except add_en depend on state only.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    mul_ready = 1'b0;
    add_en    = 1'b0;
    add_sel   = SEL_MUL_SUM;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && (len != '0)) begin
          accept    = 1'b1;
          state_nxt = SEED;
        end
      end
      SEED: begin
        add_sel   = SEL_MUL_REGS;
        mul_ready = 1'b1;
        add_en    = mul_valid;
        fire      = mul_valid;
        if (fire) begin
          state_nxt = (cnt == '0) ? POST : ACC;
        end
      end
      ACC: begin
        add_sel   = SEL_MUL_SUM;
        mul_ready = 1'b1;
        add_en    = mul_valid;
        fire      = mul_valid;
        if (fire && (cnt == '0)) begin
          state_nxt = POST;
        end
      end
`ifdef CADDER_SEQ_BIAS_EN
      BIAS: begin
        add_sel   = SEL_REGA_SUM;
        add_en    = 1'b1;
        state_nxt = SETTLE;
      end
`endif
      SETTLE: begin
        state_nxt = OUT;
      end
      OUT: begin
        if (res_valid && res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remaining-term counter: holds terms left after the current one, so the SEED fire also counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= len - LEN_W'(1);
    end else if (fire && (cnt != '0)) begin
      cnt <= cnt - LEN_W'(1);
    end
  end

  // Overflow tracking: the adder reports overflow one cycle after the add that caused it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_d       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      en_d <= add_en;
      if (accept) begin
        ovf_sticky <= 1'b0;
      end else if (en_d) begin
        ovf_sticky <= ovf_sticky | add_ovf;
      end
    end
  end

  // Saturate the settled 26-bit sum; on a wrap the true sign is the inverse of the wrapped MSB.
  always_comb begin
    ovf_final    = ovf_sticky | (en_d & add_ovf);
    res_data_nxt = add_sum[OUT_W-1:0];
    res_sat_nxt  = 1'b0;
    if (ovf_final) begin
      res_data_nxt = add_sum[25] ? RES_MAX : RES_MIN;
      res_sat_nxt  = 1'b1;
    end else if ($signed(add_sum) > SAT_MAX) begin
      res_data_nxt = RES_MAX;
      res_sat_nxt  = 1'b1;
    end else if ($signed(add_sum) < SAT_MIN) begin
      res_data_nxt = RES_MIN;
      res_sat_nxt  = 1'b1;
    end
  end

  // Result register: loaded in SETTLE, held through OUT, valid dropped on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_data  <= '0;
      res_sat   <= 1'b0;
      res_ovf   <= 1'b0;
      res_valid <= 1'b0;
    end else if (state == SETTLE) begin
      res_data  <= res_data_nxt;
      res_sat   <= res_sat_nxt;
      res_ovf   <= ovf_final;
      res_valid <= 1'b1;
    end else if ((state == OUT) && res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cadder_seq.sv
// Bench for cadder_seq with a behavioural model of the 26-bit registered adder.
// Driver issues directed jobs and pushes hand-computed results; a monitor pops and compares.
// Build with or without CADDER_SEQ_BIAS_EN; bias expectations follow the macro.
module tb_cadder_seq;
  localparam int LEN_W = 8;
  localparam int OUT_W = 21;
`ifdef CADDER_SEQ_BIAS_EN
  localparam int BIAS_ADD = 5;
  localparam int LAT_BIAS = 1;
`else
  localparam int BIAS_ADD = 0;
  localparam int LAT_BIAS = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             mul_valid = 1'b0;
  logic             mul_ready;
  logic             add_en;
  logic [1:0]       add_sel;
  logic [25:0]      add_sum;
  logic             add_ovf;
  logic [OUT_W-1:0] res_data;
  logic             res_sat;
  logic             res_ovf;
  logic             res_valid;
  logic             res_ready = 1'b1;

  logic [20:0] mul_in = '0;
  logic [25:0] regs_in = '0;
  logic [25:0] rega = 26'd5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [20:0] d;
    logic        s;
    logic        o;
    int          c;
  } exp_t;
  exp_t sb[$];
  logic [20:0] terms[$];

  cadder_seq #(.LEN_W(LEN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .add_en(add_en), .add_sel(add_sel),
    .add_sum(add_sum), .add_ovf(add_ovf), .res_data(res_data), .res_sat(res_sat),
    .res_ovf(res_ovf), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: mul_in is a 21-bit signed term sign-extended to 26 bits.
  logic [25:0] op_a, op_b, op_sum;
  always_comb begin
    op_a = {{5{mul_in[20]}}, mul_in};
    op_b = regs_in;
    if (add_sel == 2'b01) op_b = add_sum;
    if (add_sel == 2'b10) begin
      op_a = rega;
      op_b = add_sum;
    end
    op_sum = op_a + op_b;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_sum <= '0;
      add_ovf <= 1'b0;
    end else if (add_en) begin
      add_sum <= op_sum;
      add_ovf <= (op_a[25] == op_b[25]) && (op_sum[25] != op_a[25]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each new result, compare against the oldest expectation.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (res_valid && !rv_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(res_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", 32'(res_data), 32'(e.d));
        chk("res_sat", 32'(res_sat), 32'(e.s));
        chk("res_ovf", 32'(res_ovf), 32'(e.o));
        chk("res_valid_cycle", 32'(cyc), 32'(e.c));
      end
    end
    rv_prev = res_valid;
  end

  always @(posedge clk) if (res_valid && res_ready) done_cnt <= done_cnt + 1;

  task automatic fill(input int n, input logic [20:0] v);
    terms.delete();
    for (int i = 0; i < n; i++) terms.push_back(v);
  endtask

  task automatic wait_done(input int target);
    int b = 0;
    while (done_cnt < target && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (done_cnt < target) chk("result_timeout", 32'(done_cnt), 32'(target));
  endtask

  // One job: start at cycle c0, feed terms[], optional mul_valid gap before term gap_at.
  task automatic run_job(input int n, input logic [25:0] regs, input int gap_at, input int gap_len,
                         input logic [20:0] e_data, input logic e_sat, input logic e_ovf,
                         input bit wait_res);
    exp_t e;
    int idx = 0;
    int gap_left = gap_len;
    int budget = 0;
    int target;
    target = done_cnt + 1;
    @(negedge clk);
    regs_in = regs;
    start = 1'b1;
    len = LEN_W'(n);
    e.d = e_data; e.s = e_sat; e.o = e_ovf; e.c = cyc + n + 2 + LAT_BIAS + gap_len;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    while (idx < n && budget < 300) begin
      if (idx == gap_at && gap_left > 0) begin
        mul_valid = 1'b0;
        gap_left--;
        #1 chk("gap_add_en", 32'(add_en), 32'd0);
      end else begin
        mul_valid = 1'b1;
        mul_in = terms[idx];
        #1;
        if (mul_ready) idx++;
      end
      budget++;
      @(negedge clk);
    end
    mul_valid = 1'b0;
    if (idx < n) chk("feed_timeout", 32'(idx), 32'(n));
    if (wait_res) wait_done(target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_ready", 32'(mul_ready), 32'd0);
    chk("rst_add_en", 32'(add_en), 32'd0);
    chk("rst_add_sel", 32'(add_sel), 32'd1);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_sat", 32'(res_sat), 32'd0);
    chk("rst_res_ovf", 32'(res_ovf), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 10 + 100 + 200 - 50 = 260.
    terms = {21'd100, 21'd200, 21'h1FFFCE};
    run_job(3, 26'd10, -1, 0, 21'(260 + BIAS_ADD), 1'b0, 1'b0, 1'b1);
    // Same job with a two-cycle gap between terms 1 and 2.
    run_job(3, 26'd10, 1, 2, 21'(260 + BIAS_ADD), 1'b0, 1'b0, 1'b1);
    // 4 * 0x0FFFFF = 4194300: positive saturation without 26-bit overflow.
    fill(4, 21'h0FFFFF);
    run_job(4, 26'd0, -1, 0, 21'h0FFFFF, 1'b1, 1'b0, 1'b1);
    // 2 * (-1048576) = -2097152: negative saturation.
    fill(2, 21'h100000);
    run_job(2, 26'd0, -1, 0, 21'h100000, 1'b1, 1'b0, 1'b1);
    // 40 * 0x0FFFFF wraps the 26-bit sum: overflow forces +max.
    fill(40, 21'h0FFFFF);
    run_job(40, 26'd0, -1, 0, 21'h0FFFFF, 1'b1, 1'b1, 1'b1);
    // Exactly -2^20 fits (bias pulls it to -1048571).
    fill(1, 21'd0);
    run_job(1, 26'h3F00000, -1, 0, (LAT_BIAS == 1) ? 21'h100005 : 21'h100000, 1'b0, 1'b0, 1'b1);
    // Exactly +max fits; bias pushes it over.
    fill(1, 21'h0FFFFF);
    run_job(1, 26'd0, -1, 0, 21'h0FFFFF, (LAT_BIAS == 1), 1'b0, 1'b1);

    // Hold result with res_ready low; start pulse during OUT must be ignored.
    res_ready = 1'b0;
    terms = {21'd100, 21'd200, 21'h1FFFCE};
    run_job(3, 26'd10, -1, 0, 21'(260 + BIAS_ADD), 1'b0, 1'b0, 1'b0);
    begin
      int b = 0;
      while (!res_valid && b < 20) begin
        @(negedge clk);
        b++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_data", 32'(res_data), 32'(21'(260 + BIAS_ADD)));
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      start = (i == 3);
      len = LEN_W'(2);
      @(negedge clk);
    end
    start = 1'b0;
    // Handshake at t with start also at t: start ignored, IDLE at t+1.
    res_ready = 1'b1;
    start = 1'b1;
    len = LEN_W'(3);
    @(negedge clk);
    start = 1'b0;
    chk("start_at_handshake_ignored", 32'(busy), 32'd0);
    // len=0 start is ignored.
    start = 1'b1;
    len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("len0_busy_later", 32'(busy), 32'd0);

    // Reset mid-ACC (cnt=5 after two fires of an 8-term job).
    @(negedge clk);
    regs_in = 26'd0;
    start = 1'b1;
    len = LEN_W'(8);
    @(negedge clk);
    start = 1'b0;
    mul_valid = 1'b1;
    mul_in = 21'd1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre_rst_add_en", 32'(add_en), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_add_en", 32'(add_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_mul_ready", 32'(mul_ready), 32'd0);
    chk("midrst_add_sel", 32'(add_sel), 32'd1);
    mul_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    // Fresh len=1 job after reset: 7 + 3 = 10.
    fill(1, 21'd3);
    run_job(1, 26'd7, -1, 0, 21'(10 + BIAS_ADD), 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
